// File: rtl/pong_pkg.sv
// Shared pong definitions: game state encoding, detector flag bit indices,
// screen geometry and a small signed helper.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    SCORED,
    GAME_OVER
  } state_t;

  // ball_detect_edge bits, active low
  localparam int EDGE_BOTTOM = 0;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_LEFT   = 3;

  // collision_detect bits
  localparam int COL_R_X        = 0;
  localparam int COL_L_X        = 1;
  localparam int COL_R_Y        = 2;
  localparam int COL_R_TOP_IN   = 3;
  localparam int COL_R_BOT_PAST = 4;
  localparam int COL_L_Y        = 5;
  localparam int COL_L_TOP_IN   = 6;
  localparam int COL_L_BOT_PAST = 7;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  function automatic logic signed [31:0] abs32(input logic signed [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/pong_score_counter.sv
// Two saturating 4-bit player scores with a one-cycle score pulse,
// synchronous clear and win detection against WIN_SCORE.
module pong_score_counter #(
  parameter int WIN_SCORE = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc_l,
  input  logic       inc_r,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] score_event,
  output logic       win
);

  localparam logic [4:0] WIN_THRESH = 5'(WIN_SCORE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score_l     <= '0;
      score_r     <= '0;
      score_event <= '0;
    end else begin
      score_event <= {inc_r, inc_l};
      if (clr) begin
        score_l <= '0;
        score_r <= '0;
      end else begin
        if (inc_l && (score_l != '1)) score_l <= score_l + 4'd1;
        if (inc_r && (score_r != '1)) score_r <= score_r + 4'd1;
      end
    end
  end

  assign win = ({1'b0, score_l} >= WIN_THRESH) || ({1'b0, score_r} >= WIN_THRESH);

endmodule

// File: rtl/ball_motion_ctrl.sv
// Frame-rate ball controller: serve/play/score/game-over flow, velocity and
// offset ownership. Optional paddle speed-up is enabled by BALL_SPEEDUP_EN.
module ball_motion_ctrl
  import pong_pkg::*;
#(
  parameter int SPEED_X           = 2,
  parameter int SPEED_Y           = 1,
  parameter int MAX_SPEED_X       = 8,
  parameter int SCORE_HOLD_FRAMES = 60,
  parameter int WIN_SCORE         = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic [3:0]  ball_detect_edge,
  input  logic [7:0]  collision_detect,
  output logic [31:0] ball_off_x,
  output logic [31:0] ball_off_y,
  output logic [31:0] ball_vel_x,
  output logic [31:0] ball_vel_y,
  output logic [3:0]  score_L,
  output logic [3:0]  score_R,
  output logic [1:0]  score_event,
  output logic        game_over
);

`ifdef BALL_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam int HOLD_W = (SCORE_HOLD_FRAMES > 1) ? $clog2(SCORE_HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCORE_HOLD_FRAMES - 1);

  localparam logic signed [31:0] SX         = SPEED_X;
  localparam logic signed [31:0] SY         = SPEED_Y;
  localparam logic signed [31:0] SPEED_CEIL = SPEEDUP ? MAX_SPEED_X : SPEED_X;
  localparam logic signed [31:0] SPEED_STEP = SPEEDUP ? 32'sd1 : 32'sd0;

  state_t state_q, state_d;
  logic   dir_q, dir_d;  // 1: next serve goes toward -x
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic signed [31:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic signed [31:0] off_x_q, off_x_d, off_y_q, off_y_d;
  logic signed [31:0] mag, mag_hit;
  logic game_over_q;
  logic right_hit, left_hit, top_above, bot_past;
  logic inc_l, inc_r, clr, win;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    vel_x_d = vel_x_q;
    vel_y_d = vel_y_q;
    off_x_d = off_x_q;
    off_y_d = off_y_q;
    inc_l   = 1'b0;
    inc_r   = 1'b0;
    clr     = 1'b0;

    right_hit = collision_detect[COL_R_X] && collision_detect[COL_R_Y]
                && !vel_x_q[31] && (vel_x_q != '0);
    left_hit  = collision_detect[COL_L_X] && collision_detect[COL_L_Y] && vel_x_q[31];
    top_above = (collision_detect[COL_R_Y] && !collision_detect[COL_R_TOP_IN])
             || (collision_detect[COL_L_Y] && !collision_detect[COL_L_TOP_IN]);
    bot_past  = collision_detect[COL_R_BOT_PAST] || collision_detect[COL_L_BOT_PAST];

    mag     = abs32(vel_x_q);
    mag_hit = (mag + SPEED_STEP > SPEED_CEIL) ? SPEED_CEIL : mag + SPEED_STEP;

    unique case (state_q)
      IDLE: begin
        if (serve) begin
          state_d = PLAY;
          vel_x_d = dir_q ? -SX : SX;
          vel_y_d = SY;
          off_x_d = '0;
          off_y_d = '0;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (right_hit || left_hit) begin
            vel_x_d = right_hit ? -mag_hit : mag_hit;
            if (top_above)     vel_y_d = -SY;
            else if (bot_past) vel_y_d = SY;
          end else if (!ball_detect_edge[EDGE_LEFT] || !ball_detect_edge[EDGE_RIGHT]) begin
            // left wall checked first; its point goes to R
            if (!ball_detect_edge[EDGE_LEFT]) begin
              inc_r = 1'b1;
              dir_d = 1'b1;
            end else begin
              inc_l = 1'b1;
              dir_d = 1'b0;
            end
            state_d = SCORED;
            hold_d  = '0;
            vel_x_d = '0;
            vel_y_d = '0;
            off_x_d = '0;
            off_y_d = '0;
          end else begin
            if (!ball_detect_edge[EDGE_TOP] && vel_y_q[31])
              vel_y_d = SY;
            else if (!ball_detect_edge[EDGE_BOTTOM] && !vel_y_q[31] && (vel_y_q != '0))
              vel_y_d = -SY;
          end
          if (state_d == PLAY) begin
            off_x_d = off_x_q + vel_x_d;
            off_y_d = off_y_q + vel_y_d;
          end
        end
      end
      SCORED: begin
        if (frame_tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = win ? GAME_OVER : IDLE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (serve) begin
          clr     = 1'b1;
          dir_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      hold_q      <= '0;
      vel_x_q     <= '0;
      vel_y_q     <= '0;
      off_x_q     <= '0;
      off_y_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      hold_q      <= hold_d;
      vel_x_q     <= vel_x_d;
      vel_y_q     <= vel_y_d;
      off_x_q     <= off_x_d;
      off_y_q     <= off_y_d;
      game_over_q <= (state_d == GAME_OVER);
    end
  end

  pong_score_counter #(
    .WIN_SCORE(WIN_SCORE)
  ) u_score (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .inc_l      (inc_l),
    .inc_r      (inc_r),
    .score_l    (score_L),
    .score_r    (score_R),
    .score_event(score_event),
    .win        (win)
  );

  assign ball_off_x = off_x_q;
  assign ball_off_y = off_y_q;
  assign ball_vel_x = vel_x_q;
  assign ball_vel_y = vel_y_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed self-checking bench for ball_motion_ctrl: vector table for play
// physics plus hand-written score-hold, game-over and reset sequences.
module tb_ball_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        serve;
  logic [3:0]  edges;
  logic [7:0]  col;
  logic [31:0] ball_off_x, ball_off_y, ball_vel_x, ball_vel_y;
  logic [3:0]  score_L, score_R;
  logic [1:0]  score_event;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  ball_motion_ctrl #(
    .SPEED_X          (2),
    .SPEED_Y          (1),
    .MAX_SPEED_X      (8),
    .SCORE_HOLD_FRAMES(60),
    .WIN_SCORE        (9)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_tick      (frame_tick),
    .serve           (serve),
    .ball_detect_edge(edges),
    .collision_detect(col),
    .ball_off_x      (ball_off_x),
    .ball_off_y      (ball_off_y),
    .ball_vel_x      (ball_vel_x),
    .ball_vel_y      (ball_vel_y),
    .score_L         (score_L),
    .score_R         (score_R),
    .score_event     (score_event),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         tk;
    logic [3:0] edg;
    logic [7:0] col;
    int         vx, vy, ox, oy, sev, sl, sr;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int vx, input int vy, input int ox,
                         input int oy, input int sev, input int sl, input int sr);
    chk({tag, "_vx"}, $signed(ball_vel_x), vx);
    chk({tag, "_vy"}, $signed(ball_vel_y), vy);
    chk({tag, "_ox"}, $signed(ball_off_x), ox);
    chk({tag, "_oy"}, $signed(ball_off_y), oy);
    chk({tag, "_sev"}, int'(score_event), sev);
    chk({tag, "_sl"}, int'(score_L), sl);
    chk({tag, "_sr"}, int'(score_R), sr);
  endtask

  task automatic step(input bit tk, input logic [3:0] e, input logic [7:0] c);
    @(negedge clk);
    frame_tick = tk;
    edges      = e;
    col        = c;
    @(negedge clk);
    frame_tick = 1'b0;
    edges      = 4'hF;
    col        = 8'h00;
  endtask

  task automatic pulse_serve(input bit with_tick);
    @(negedge clk);
    serve      = 1'b1;
    frame_tick = with_tick;
    @(negedge clk);
    serve      = 1'b0;
    frame_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              tk  edge   col    vx  vy  ox  oy sev sl sr
    vecs[0]  = '{1'b1, 4'hF, 8'h00,  2,  1,  2,  1, 0, 0, 0};
    vecs[1]  = '{1'b1, 4'hF, 8'h00,  2,  1,  4,  2, 0, 0, 0};
    vecs[2]  = '{1'b1, 4'hF, 8'h00,  2,  1,  6,  3, 0, 0, 0};
    vecs[3]  = '{1'b0, 4'h0, 8'hFF,  2,  1,  6,  3, 0, 0, 0};
    vecs[4]  = '{1'b1, 4'hF, 8'h05, -2, -1,  4,  2, 0, 0, 0};
    vecs[5]  = '{1'b1, 4'hB, 8'h00, -2,  1,  2,  3, 0, 0, 0};
    vecs[6]  = '{1'b1, 4'hE, 8'h00, -2, -1,  0,  2, 0, 0, 0};
    vecs[7]  = '{1'b1, 4'hE, 8'h00, -2, -1, -2,  1, 0, 0, 0};
    vecs[8]  = '{1'b1, 4'hF, 8'hE2,  2,  1,  0,  2, 0, 0, 0};
    vecs[9]  = '{1'b1, 4'hF, 8'h22,  2,  1,  2,  3, 0, 0, 0};
    vecs[10] = '{1'b1, 4'hF, 8'h1D, -2,  1,  0,  4, 0, 0, 0};
    vecs[11] = '{1'b1, 4'h7, 8'h22,  2, -1,  2,  3, 0, 0, 0};
    vecs[12] = '{1'b1, 4'h7, 8'h00,  0,  0,  0,  0, 2, 0, 1};

    rst_n = 1'b0; frame_tick = 1'b0; serve = 1'b0; edges = 4'hF; col = 8'h00;
    repeat (3) @(negedge clk);
    chk_all("rst", 0, 0, 0, 0, 0, 0, 0);
    chk("rst_go", int'(game_over), 0);
    rst_n = 1'b1;

`ifdef BALL_SPEEDUP_EN
    pulse_serve(1'b0);
    chk("su_serve_vx", $signed(ball_vel_x), 2);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'hF, (i % 2 == 0) ? 8'h05 : 8'h22);
      if (i == 4) chk("su_hit5_vx", $signed(ball_vel_x), -7);
    end
    chk("su_cap_vx", $signed(ball_vel_x), 8);
`else
    pulse_serve(1'b0);
    chk_all("serve", 2, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].tk, vecs[i].edg, vecs[i].col);
      chk_all($sformatf("v%0d", i), vecs[i].vx, vecs[i].vy, vecs[i].ox, vecs[i].oy,
              vecs[i].sev, vecs[i].sl, vecs[i].sr);
    end

    @(negedge clk);
    chk("sev_clear", int'(score_event), 0);

    // hold for exactly 60 ticks; serve before the last one is ignored
    repeat (59) step(1'b1, 4'hF, 8'h00);
    pulse_serve(1'b0);
    chk("hold_serve_ignored_vx", $signed(ball_vel_x), 0);
    step(1'b1, 4'hF, 8'h00);
    chk("hold_end_vx", $signed(ball_vel_x), 0);

    // serve with a coincident tick: serve taken, no motion yet
    pulse_serve(1'b1);
    chk_all("reserve", -2, 1, 0, 0, 0, 0, 1);
    step(1'b1, 4'hF, 8'h00);
    chk_all("reserve_move", -2, 1, -2, 1, 0, 0, 1);

    for (int i = 0; i < 9; i++) begin
      step(1'b1, 4'hD, 8'h00);
      chk($sformatf("lscore%0d_sl", i), int'(score_L), i + 1);
      chk($sformatf("lscore%0d_sev", i), int'(score_event), 1);
      repeat (59) step(1'b1, 4'hF, 8'h00);
      if (i == 8) chk("go_before_hold_end", int'(game_over), 0);
      step(1'b1, 4'hF, 8'h00);
      if (i < 8) begin
        chk($sformatf("lscore%0d_go", i), int'(game_over), 0);
        pulse_serve(1'b0);
        chk($sformatf("lscore%0d_serve_vx", i), $signed(ball_vel_x), 2);
      end else begin
        chk("game_over_set", int'(game_over), 1);
      end
    end

    pulse_serve(1'b0);
    chk("go_clear", int'(game_over), 0);
    chk("go_sl", int'(score_L), 0);
    chk("go_sr", int'(score_R), 0);
    chk("go_vx", $signed(ball_vel_x), 0);
    pulse_serve(1'b0);
    chk("go_reserve_vx", $signed(ball_vel_x), 2);

    step(1'b1, 4'hF, 8'h00);
    chk("pre_rst_ox", $signed(ball_off_x), 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_go", int'(game_over), 0);
    step(1'b1, 4'hF, 8'h00);
    chk_all("midrst_idle", 0, 0, 0, 0, 0, 0, 0);
    pulse_serve(1'b0);
    chk("midrst_serve_vx", $signed(ball_vel_x), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
